// File: rtl/cfg_shift_chain.sv
// rtl/cfg_shift_chain.sv - multi-lane configuration shift chain with commit/release sequencer
module cfg_shift_chain #(
    parameter int WIDTH = 32,
    parameter int LANES = 1
) (
    input  logic             CK,
    input  logic             RSTN,
    input  logic             start,
    input  logic [LANES-1:0] SI,
    input  logic             si_valid,
    output logic             si_ready,
    output logic [LANES-1:0] SO,
    output logic [WIDTH-1:0] cfg_q,
    output logic             cfg_done,
    output logic             busy,
    output logic             err
);

    localparam int N_BEATS = WIDTH / LANES;
    localparam int CW      = (N_BEATS > 1) ? $clog2(N_BEATS) : 1;
    localparam logic [CW-1:0] LAST_BEAT = CW'(N_BEATS - 1);

    typedef enum logic [1:0] {
        S_IDLE   = 2'd0,
        S_SHIFT  = 2'd1,
        S_COMMIT = 2'd2,
        S_DONE   = 2'd3
    } state_t;

    state_t           state;
    logic [CW-1:0]    beat_cnt;
    logic [WIDTH-1:0] chain;
    logic [WIDTH-1:0] shadow;
    logic [WIDTH-1:0] chain_shifted;
    logic             accept;
    logic             start_ok;
    logic             violation;

    // A chain exactly one beat wide is simply replaced by the incoming beat.
    generate
        if (WIDTH == LANES) begin : g_single_beat
            assign chain_shifted = SI;
        end else begin : g_multi_beat
            assign chain_shifted = {chain[WIDTH-LANES-1:0], SI};
        end
    endgenerate

    assign si_ready = (state == S_SHIFT);
    assign busy     = (state == S_SHIFT) || (state == S_COMMIT);
    assign SO       = chain[WIDTH-1 -: LANES];
    assign cfg_q    = cfg_done ? shadow : '0;

    // Handshake decode and protocol-violation detection for this cycle.
    always_comb begin
        accept    = si_valid && si_ready;
        start_ok  = start && !busy;
        violation = (si_valid && !si_ready) || (start && busy);
    end

    // Load sequencer: shift beats in, commit to shadow, release on done.
    always_ff @(posedge CK or negedge RSTN) begin
        if (!RSTN) begin
            state    <= S_IDLE;
            beat_cnt <= '0;
            chain    <= '0;
            shadow   <= '0;
            cfg_done <= 1'b0;
            err      <= 1'b0;
        end else begin
            // An accepted start clears err, but a violation in the same cycle re-sets it.
            err <= (start_ok ? 1'b0 : err) | violation;
            case (state)
                S_IDLE, S_DONE: begin
                    if (start) begin
                        state    <= S_SHIFT;
                        beat_cnt <= '0;
                        cfg_done <= 1'b0;
                    end
                end
                S_SHIFT: begin
                    if (accept) begin
                        chain <= chain_shifted;
                        if (beat_cnt == LAST_BEAT) begin
                            state <= S_COMMIT;
                        end else begin
                            beat_cnt <= beat_cnt + 1'b1;
                        end
                    end
                end
                S_COMMIT: begin
                    shadow   <= chain;
                    cfg_done <= 1'b1;
                    state    <= S_DONE;
                end
                default: state <= S_IDLE;
            endcase
        end
    end

endmodule

// File: tb/tb_cfg_shift_chain.sv
// tb/tb_cfg_shift_chain.sv - self-checking bench for cfg_shift_chain
module tb_cfg_shift_chain;

    localparam int WIDTH = 8;
    localparam int LANES = 2;
    localparam int NB    = WIDTH / LANES;

    logic             CK = 1'b0;
    logic             RSTN;
    logic             start;
    logic [LANES-1:0] SI;
    logic             si_valid;
    logic             si_ready;
    logic [LANES-1:0] SO;
    logic [WIDTH-1:0] cfg_q;
    logic             cfg_done;
    logic             busy;
    logic             err;

    int errors = 0;
    int checks = 0;

    always #5 CK = ~CK;

    cfg_shift_chain #(.WIDTH(WIDTH), .LANES(LANES)) dut (
        .CK       (CK),
        .RSTN     (RSTN),
        .start    (start),
        .SI       (SI),
        .si_valid (si_valid),
        .si_ready (si_ready),
        .SO       (SO),
        .cfg_q    (cfg_q),
        .cfg_done (cfg_done),
        .busy     (busy),
        .err      (err)
    );

    // Reference model: phase flags, a beat count and integer chain arithmetic.
    bit               m_loading, m_commit, m_done, m_err;
    int               m_cnt;
    logic [WIDTH-1:0] m_chain, m_shadow;

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        checks++;
        assert (obs === exp) else begin
            errors++;
            $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
        end
    endtask

    task automatic model_reset();
        m_loading = 0; m_commit = 0; m_done = 0; m_err = 0;
        m_cnt = 0; m_chain = '0; m_shadow = '0;
    endtask

    task automatic model_step(input bit s, input logic [LANES-1:0] d, input bit v);
        bit inflight;
        bit viol;
        inflight = m_loading || m_commit;
        viol     = (v && !m_loading) || (s && inflight);
        if (m_commit) begin
            m_shadow = m_chain;
            m_done   = 1;
            m_commit = 0;
        end else if (m_loading) begin
            if (v) begin
                m_chain = (m_chain << LANES) | WIDTH'(d);
                m_cnt++;
                if (m_cnt == NB) begin
                    m_loading = 0;
                    m_commit  = 1;
                end
            end
        end else if (s) begin
            m_loading = 1;
            m_cnt     = 0;
            m_done    = 0;
        end
        if (!inflight && s) m_err = 0;
        if (viol) m_err = 1;
    endtask

    task automatic check_all(input string ctx);
        chk({ctx, ".si_ready"}, 32'(si_ready), 32'(m_loading));
        chk({ctx, ".busy"},     32'(busy),     32'(m_loading || m_commit));
        chk({ctx, ".SO"},       32'(SO),       32'(m_chain >> (WIDTH - LANES)));
        chk({ctx, ".cfg_q"},    32'(cfg_q),    m_done ? 32'(m_shadow) : 32'd0);
        chk({ctx, ".cfg_done"}, 32'(cfg_done), 32'(m_done));
        chk({ctx, ".err"},      32'(err),      32'(m_err));
    endtask

    task automatic cyc(input string ctx, input bit s, input logic [LANES-1:0] d, input bit v);
        start = s; SI = d; si_valid = v;
        @(posedge CK);
        model_step(s, d, v);
        #1;
        check_all(ctx);
        start = 1'b0; si_valid = 1'b0; SI = '0;
    endtask

    initial begin
        logic [LANES-1:0] beats_a [4];
        beats_a = '{2'd3, 2'd2, 2'd1, 2'd0};
        RSTN = 1'b0; start = 1'b0; SI = '0; si_valid = 1'b0;
        model_reset();
        repeat (2) @(posedge CK);
        #1;
        check_all("reset");
        @(negedge CK);
        RSTN = 1'b1;
        #1;

        // First load 3,2,1,0 back to back: done exactly 6 cycles after start.
        cyc("load1.start", 1'b1, 2'd0, 1'b0);
        for (int i = 0; i < NB; i++) cyc("load1.beat", 1'b0, beats_a[i], 1'b1);
        chk("load1.busy_c5", 32'(busy), 32'd1);
        chk("load1.done_c5", 32'(cfg_done), 32'd0);
        cyc("load1.commit", 1'b0, 2'd0, 1'b0);
        chk("load1.done_c6", 32'(cfg_done), 32'd1);
        chk("load1.cfg_q", 32'(cfg_q), 32'hE4);

        // Second load of zeros: SO reads back 3,2,1,0; cfg_q is 0 until commit.
        cyc("load2.start", 1'b1, 2'd0, 1'b0);
        chk("load2.cfg_q_cleared", 32'(cfg_q), 32'd0);
        for (int i = 0; i < NB; i++) begin
            chk("load2.readback", 32'(SO), 32'(beats_a[i]));
            cyc("load2.beat", 1'b0, 2'd0, 1'b1);
        end
        cyc("load2.commit", 1'b0, 2'd0, 1'b0);
        chk("load2.cfg_q", 32'(cfg_q), 32'h00);
        chk("load2.done", 32'(cfg_done), 32'd1);

        // Gapped load: si_valid alternates 0/1, done after 10 cycles, no err.
        cyc("gap.start", 1'b1, 2'd0, 1'b0);
        for (int i = 0; i < NB; i++) begin
            cyc("gap.idle", 1'b0, 2'd0, 1'b0);
            cyc("gap.beat", 1'b0, beats_a[i], 1'b1);
        end
        chk("gap.done_c9", 32'(cfg_done), 32'd0);
        cyc("gap.commit", 1'b0, 2'd0, 1'b0);
        chk("gap.done_c10", 32'(cfg_done), 32'd1);
        chk("gap.cfg_q", 32'(cfg_q), 32'hE4);
        chk("gap.err", 32'(err), 32'd0);

        // si_valid while DONE: err sets, data dropped; next start clears err.
        cyc("done_err.push", 1'b0, 2'd1, 1'b1);
        chk("done_err.err", 32'(err), 32'd1);
        chk("done_err.cfg_q", 32'(cfg_q), 32'hE4);
        chk("done_err.SO", 32'(SO), 32'd3);
        cyc("done_err.restart", 1'b1, 2'd0, 1'b0);
        chk("done_err.cleared", 32'(err), 32'd0);

        // Reset mid-load after two beats, then a fresh load of 1,1,1,1.
        cyc("rst.beat", 1'b0, 2'd2, 1'b1);
        cyc("rst.beat", 1'b0, 2'd2, 1'b1);
        #2;
        RSTN = 1'b0;
        model_reset();
        #1;
        check_all("rst.async");
        chk("rst.cfg_q", 32'(cfg_q), 32'd0);
        @(negedge CK);
        RSTN = 1'b1;
        #1;
        cyc("reload.start", 1'b1, 2'd0, 1'b0);
        for (int i = 0; i < NB; i++) cyc("reload.beat", 1'b0, 2'd1, 1'b1);
        cyc("reload.commit", 1'b0, 2'd0, 1'b0);
        chk("reload.cfg_q", 32'(cfg_q), 32'h55);

        // Start together with si_valid in DONE: start taken, beat dropped, err set.
        cyc("startvalid", 1'b1, 2'd3, 1'b1);
        chk("startvalid.err", 32'(err), 32'd1);
        chk("startvalid.ready", 32'(si_ready), 32'd1);

        // Randomized traffic including stray starts and pushes outside SHIFT.
        for (int n = 0; n < 400; n++) begin
            cyc("rand", ($urandom_range(0, 9) == 0), LANES'($urandom), ($urandom_range(0, 9) < 6));
        end

        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule
